muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative multiply/divide unit implementing the RV32M funct3 operations for the core's execute stage. It is generalised in DATA_W and sits beside the ALU. The datapath raises start with operands, holds the instruction while busy, and writes result back when done pulses. It uses one shared shift/add/subtract engine with sign pre- and post-correction.

Parameters:
DATA_W, 32, operand/result width (even, >=8)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  request; sampled only in IDLE or DONE
op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  in  DATA_W  operand A / dividend
rs2  in  DATA_W  operand B / divisor
flush  in  1  synchronous abort (pipeline kill)
busy  out  1  high in CALC and FIX
done  out  1  one-cycle pulse, high in DONE only
result  out  DATA_W  registered result; held until next accepted start

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, busy=0, done=0, result=0, counter=0, internal regs=0.
- States:
  - IDLE: start=1 -> CALC, or -> DONE on the special/fast paths below.
  - CALC: one iteration per cycle; after DATA_W iterations -> FIX.
  - FIX: apply sign correction and select the result -> DONE.
  - DONE: start=1 behaves as in IDLE (back-to-back issue); otherwise -> IDLE.
- Timing: start is sampled at edge 0. The normal path has done high between edge DATA_W+1 and edge DATA_W+2 (edges 33 and 34 for DATA_W=32). The fast path has done high between edge 0 and edge 1.
- start while busy: ignored; no queueing.
- Operands and op are captured at the start edge; later changes to the inputs have no effect.
- Multiply: operands are converted to magnitudes according to signedness (MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU/MUL unsigned magnitude path).
  - Radix-2 shift-add into a 2*DATA_W product.
  - FIX negates the product if the operand signs differ.
  - MUL returns the low DATA_W bits; MULH* return the high DATA_W bits.
  - MUL result is identical for signed and unsigned interpretation.
- Divide: restoring division on magnitudes (DIV/REM signed, DIVU/REMU unsigned).
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
- Special cases (fast path, IDLE -> DONE in one cycle):
  - Divisor zero: quotient all-ones; remainder = rs1.
  - Signed overflow (rs1 = 1 followed by zeros, i.e. 100...0; rs2 = all-ones, i.e. -1; op DIV/REM): quotient = rs1, remainder = 0.
- flush=1 in any state: next edge -> IDLE, busy=0, done=0, result unchanged. flush has priority over start in the same cycle.
- Reset asserted mid-operation: immediate return to reset values; no done is produced.

Optional Feature:
MULDIV_FAST_ZERO_EN
- Defined:
  - Multiply with either operand zero -> fast path, result 0.
  - Divide/remainder with rs1=0 and rs2!=0 -> fast path, quotient 0, remainder 0.
- Undefined: these cases take the full DATA_W+2-cycle path and produce identical values. Only latency differs; divide-by-zero and overflow remain fast in both builds.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB; done high between edge 33 and edge 34 only; busy high for exactly 33 cycles.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. Second start issued in the DONE cycle is accepted back-to-back.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. All with done between edge 0 and edge 1.
- Start DIV, assert flush at cycle 10 -> busy=0 next edge, no done pulse, result equals the previous value. A start pulsed while busy in a separate run -> ignored.
- reset=0 mid-CALC -> busy/done/result go to 0 without a clock. With MULDIV_FAST_ZERO_EN, MUL 0*5 -> done between edge 0 and edge 1, result 0; without it -> done between edge 33 and edge 34, result 0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shared shift/add/subtract engine with sign pre/post-correction.
// Optional build macro MULDIV_FAST_ZERO_EN: zero-operand multiplies and zero-dividend divides complete on the fast path.
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs1,
    input  logic [DATA_W-1:0] rs2,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  counter;
    logic [2:0]        op_q;
    logic              neg_q;
    logic              neg_r;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] b_reg;

    logic              a_sgn;
    logic              b_sgn;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic              fast_hit;
    logic [DATA_W-1:0] fast_res;

    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;
    logic [DATA_W-1:0]   fix_res;

    // Operand signedness and magnitudes for the accepted instruction
    always_comb begin
        a_sgn = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_sgn = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_neg = a_sgn & rs1[DATA_W-1];
        b_neg = b_sgn & rs2[DATA_W-1];
        a_mag = a_neg ? ('0 - rs1) : rs1;
        b_mag = b_neg ? ('0 - rs2) : rs2;
    end

    always_comb begin
        fast_hit = 1'b0;
        fast_res = '0;
        if (op[2] && (rs2 == '0)) begin
            fast_hit = 1'b1;
            fast_res = op[1] ? rs1 : '1;
        end else if (op[2] && !op[0] && (rs1 == MIN_NEG) && (rs2 == '1)) begin
            fast_hit = 1'b1;
            fast_res = op[1] ? '0 : rs1;
        end
`ifdef MULDIV_FAST_ZERO_EN
        else if (!op[2] && ((rs1 == '0) || (rs2 == '0))) begin
            fast_hit = 1'b1;
        end else if (op[2] && (rs1 == '0)) begin
            fast_hit = 1'b1;
        end
`else
`endif
    end

    // {acc, lo} is the product register when multiplying and {remainder, dividend/quotient} when dividing
    always_comb begin
        mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, b_reg} : '0);
        div_shift = {acc, lo[DATA_W-1]};
        div_diff  = div_shift - {1'b0, b_reg};
        prod_fix  = neg_q ? ('0 - {acc, lo}) : {acc, lo};
        quo_fix   = neg_q ? ('0 - lo) : lo;
        rem_fix   = neg_r ? ('0 - acc) : acc;
        if (op_q[2]) begin
            fix_res = op_q[1] ? rem_fix : quo_fix;
        end else if (op_q == 3'b000) begin
            fix_res = prod_fix[DATA_W-1:0];
        end else begin
            fix_res = prod_fix[2*DATA_W-1:DATA_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            counter <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            acc     <= '0;
            lo      <= '0;
            b_reg   <= '0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        op_q    <= op;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        acc     <= '0;
                        lo      <= a_mag;
                        b_reg   <= b_mag;
                        counter <= '0;
                        if (fast_hit) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= fast_res;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (op_q[2]) begin
                        if (!div_diff[DATA_W]) begin
                            acc <= div_diff[DATA_W-1:0];
                            lo  <= {lo[DATA_W-2:0], 1'b1};
                        end else begin
                            acc <= div_shift[DATA_W-1:0];
                            lo  <= {lo[DATA_W-2:0], 1'b0};
                        end
                    end else begin
                        acc <= mul_sum[DATA_W:1];
                        lo  <= {mul_sum[0], lo[DATA_W-1:1]};
                    end
                    counter <= counter + 1'b1;
                    if (counter == CNT_W'(DATA_W - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result <= fix_res;
                    state  <= DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, randomized ops against an arithmetic model,
// back-to-back issue, flush, start-while-busy, asynchronous reset and the MULDIV_FAST_ZERO_EN latency split.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;
    localparam int NORM_LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] rs1 = '0;
    logic [W-1:0] rs2 = '0;
    logic         flush = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int tests_run = 0;
    int fails = 0;

    muldiv_unit #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // RV32M semantics computed with 64-bit arithmetic
    function automatic logic [W-1:0] ref_res(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0] up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        up = {32'b0, a} * {32'b0, b};
        case (o)
            3'd0: return up[31:0];
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * $signed({32'b0, b}); return sp[63:32]; end
            3'd3: return up[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return a;
                sp = sa / sb; return sp[31:0];
            end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
                sp = sa % sb; return sp[31:0];
            end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic bit exp_fast(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        if (o[2] && b == 0) return 1'b1;
        if ((o == 3'd4 || o == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1'b1;
`ifdef MULDIV_FAST_ZERO_EN
        if (!o[2] && (a == 0 || b == 0)) return 1'b1;
        if (o[2] && a == 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return MIN_NEG;
            4: return 32'h7FFF_FFFF;
            5: return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    // Issue one op at the next edge (edge 0) and wait for done; lat = edges after edge 0, -1 on timeout
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output int lat, output int bcnt);
        op = o; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = 3'($urandom_range(0, 7)); rs1 = $urandom; rs2 = $urandom;
        lat = 0; bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
        res = result;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
        tests_run++; if (result !== '0) begin fails++; $display("FAIL reset_result got=%h exp=0", result); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [2:0]   vo [12];
        logic [W-1:0] va [12], vb [12], ve [12];
        logic [W-1:0] res;
        int lat, bcnt, elat;
        vo[0]  = 3'd0; va[0]  = 32'd7;        vb[0]  = 32'hFFFF_FFFD; ve[0]  = 32'hFFFF_FFEB;
        vo[1]  = 3'd1; va[1]  = MIN_NEG;      vb[1]  = MIN_NEG;       ve[1]  = 32'h4000_0000;
        vo[2]  = 3'd3; va[2]  = 32'hFFFF_FFFF; vb[2] = 32'hFFFF_FFFF; ve[2]  = 32'hFFFF_FFFE;
        vo[3]  = 3'd2; va[3]  = 32'hFFFF_FFFF; vb[3] = 32'hFFFF_FFFF; ve[3]  = 32'hFFFF_FFFF;
        vo[4]  = 3'd4; va[4]  = 32'hFFFF_FFF9; vb[4] = 32'd2;         ve[4]  = 32'hFFFF_FFFD;
        vo[5]  = 3'd6; va[5]  = 32'hFFFF_FFF9; vb[5] = 32'd2;         ve[5]  = 32'hFFFF_FFFF;
        vo[6]  = 3'd5; va[6]  = 32'd100;      vb[6]  = 32'd7;         ve[6]  = 32'd14;
        vo[7]  = 3'd7; va[7]  = 32'd100;      vb[7]  = 32'd7;         ve[7]  = 32'd2;
        vo[8]  = 3'd5; va[8]  = 32'd5;        vb[8]  = 32'd0;         ve[8]  = 32'hFFFF_FFFF;
        vo[9]  = 3'd6; va[9]  = 32'd5;        vb[9]  = 32'd0;         ve[9]  = 32'd5;
        vo[10] = 3'd4; va[10] = MIN_NEG;      vb[10] = 32'hFFFF_FFFF; ve[10] = MIN_NEG;
        vo[11] = 3'd6; va[11] = MIN_NEG;      vb[11] = 32'hFFFF_FFFF; ve[11] = 32'd0;
        for (int i = 0; i < 12; i++) begin
            elat = (i >= 8) ? 0 : NORM_LAT;
            do_op(vo[i], va[i], vb[i], res, lat, bcnt);
            tests_run++; if (res !== ve[i]) begin fails++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, ve[i]); end
            tests_run++; if (lat != elat) begin fails++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, elat); end
            tests_run++; if (bcnt != elat) begin fails++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bcnt, elat); end
            @(posedge clk); #1;
            tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, done); end
        end
    endtask

    task automatic test_random();
        logic [2:0]   o;
        logic [W-1:0] a, b, res;
        int lat, bcnt, elat;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            elat = exp_fast(o, a, b) ? 0 : NORM_LAT;
            do_op(o, a, b, res, lat, bcnt);
            tests_run++;
            if (res !== ref_res(o, a, b)) begin
                fails++; $display("FAIL rand_result op=%0d a=%h b=%h got=%h exp=%h", o, a, b, res, ref_res(o, a, b));
            end
            tests_run++; if (lat != elat) begin fails++; $display("FAIL rand_latency op=%0d got=%0d exp=%0d", o, lat, elat); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] res;
        int lat, bcnt;
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, res, lat, bcnt);
        tests_run++; if (res !== 32'hFFFF_FFFD) begin fails++; $display("FAIL b2b_first got=%h exp=fffffffd", res); end
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, res, lat, bcnt);
        tests_run++; if (res !== 32'hFFFF_FFFF) begin fails++; $display("FAIL b2b_second got=%h exp=ffffffff", res); end
        tests_run++; if (lat != NORM_LAT) begin fails++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, NORM_LAT); end
        do_op(3'd7, 32'd9, 32'd0, res, lat, bcnt);
        tests_run++; if (res !== 32'd9) begin fails++; $display("FAIL b2b_fast got=%h exp=9", res); end
        do_op(3'd5, 32'd100, 32'd7, res, lat, bcnt);
        tests_run++; if (res !== 32'd14) begin fails++; $display("FAIL b2b_after_fast got=%h exp=e", res); end
        tests_run++; if (lat != NORM_LAT) begin fails++; $display("FAIL b2b_after_fast_latency got=%0d exp=%0d", lat, NORM_LAT); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int seen;
        op = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy got=%b exp=0", busy); end
        tests_run++; if (result !== 32'd14) begin fails++; $display("FAIL flush_result got=%h exp=e", result); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        tests_run++; if (seen != 0) begin fails++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
        op = 3'd5; rs1 = 32'd50; rs2 = 32'd5; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_over_start_busy got=%b exp=0", busy); end
        tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL flush_over_start_done got=%b exp=0", done); end
    endtask

    task automatic test_start_while_busy();
        int lat;
        op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            if (lat == 5) begin start = 1'b1; op = 3'd0; rs1 = 32'd3; rs2 = 32'd3; end
            else start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        if (!done) lat = -1;
        tests_run++; if (result !== 32'd14) begin fails++; $display("FAIL busy_start_result got=%h exp=e", result); end
        tests_run++; if (lat != NORM_LAT) begin fails++; $display("FAIL busy_start_latency got=%0d exp=%0d", lat, NORM_LAT); end
        @(posedge clk); #1;
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_start_not_queued got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        int seen;
        op = 3'd0; rs1 = 32'd12345; rs2 = 32'd678; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL rst_mid_done got=%b exp=0", done); end
        tests_run++; if (result !== '0) begin fails++; $display("FAIL rst_mid_result got=%h exp=0", result); end
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        tests_run++; if (seen != 0) begin fails++; $display("FAIL rst_mid_no_done got=%0d exp=0", seen); end
    endtask

    task automatic test_fast_zero();
        logic [W-1:0] res;
        int lat, bcnt, elat;
`ifdef MULDIV_FAST_ZERO_EN
        elat = 0;
`else
        elat = NORM_LAT;
`endif
        do_op(3'd0, 32'd0, 32'd5, res, lat, bcnt);
        tests_run++; if (res !== '0) begin fails++; $display("FAIL fz_mul_result got=%h exp=0", res); end
        tests_run++; if (lat != elat) begin fails++; $display("FAIL fz_mul_latency got=%0d exp=%0d", lat, elat); end
        do_op(3'd4, 32'd0, 32'd5, res, lat, bcnt);
        tests_run++; if (res !== '0) begin fails++; $display("FAIL fz_div_result got=%h exp=0", res); end
        tests_run++; if (lat != elat) begin fails++; $display("FAIL fz_div_latency got=%0d exp=%0d", lat, elat); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_start_while_busy();
        test_reset_mid();
        test_fast_zero();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
